// File: rtl/bcd2bin_seq.sv
// rtl/bcd2bin_seq.sv - sequential BCD-to-binary converter (reverse double-dabble)
module bcd2bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    generate
        if ((longint'(1) << BIN_W) <= pow10(DIGITS) - 1) begin : g_width_check
            $error("bcd2bin_seq: BIN_W too narrow for DIGITS");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

    state_t             state, state_nxt;
    logic [BCD_W-1:0]   bcd_sr, bcd_shift, bcd_step;
    logic [BIN_W-1:0]   bin_sr, bin_step;
    logic [CNT_W-1:0]   cnt;
    logic               bad, in_bad, last_step;

    assign last_step = (cnt == CNT_W'(BIN_W - 1));

    // One shift step, then pull 3 out of any BCD nibble that landed at >= 8.
    always_comb begin
        bcd_shift = {1'b0, bcd_sr[BCD_W-1:1]};
        bin_step  = {bcd_sr[0], bin_sr[BIN_W-1:1]};
        bcd_step  = bcd_shift;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_shift[4*i +: 4] >= 4'd8)
                bcd_step[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
        end
    end

    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) in_bad = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONV;
            CONV:    if (last_step) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ready = (state == IDLE);
    assign busy  = (state == CONV) || (state == FIN);
    assign done  = (state == FIN);

    // Result is registered on the final shift so it is already valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_sr  <= '0;
            bin_sr  <= '0;
            cnt     <= '0;
            bad     <= 1'b0;
            bin_out <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bcd_sr <= bcd_in;
                        bin_sr <= '0;
                        cnt    <= '0;
                        bad    <= in_bad;
                    end
                end
                CONV: begin
                    bcd_sr <= bcd_step;
                    bin_sr <= bin_step;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_step) begin
                        bin_out <= bad ? '0 : bin_step;
                        err     <= bad;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb/tb_bcd2bin_seq.sv - directed self-checking bench for bcd2bin_seq
module tb_bcd2bin_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] bcd_in;
    logic        ready;
    logic        busy;
    logic        done;
    logic [9:0]  bin_out;
    logic        err;

    int checks;
    int errors;

    bcd2bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bcd_to_int(input logic [11:0] v);
        return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [11:0] int_to_bcd(input int n);
        logic [11:0] r;
        r[11:8] = 4'((n / 100) % 10);
        r[7:4]  = 4'((n / 10) % 10);
        r[3:0]  = 4'(n % 10);
        return r;
    endfunction

    // Stimulus only: one accepted start, then wait (bounded) for done.
    task automatic run_conv(input logic [11:0] v, output logic [9:0] b, output logic e,
                            output int lat, output int nready);
        logic found;
        found  = 1'b0;
        lat    = 0;
        nready = 0;
        b      = '0;
        e      = 1'b0;
        @(negedge clk);
        bcd_in = v;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk);
            lat++;
            if (!ready) nready++;
            if (done) begin
                found = 1'b1;
                b     = bin_out;
                e     = err;
            end
        end
        if (!found) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bcd_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({ready, busy, done, bin_out, err} !== {1'b1, 1'b0, 1'b0, 10'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got r=%0b b=%0b d=%0b bin=%0d e=%0b want r=1 b=0 d=0 bin=0 e=0",
                     ready, busy, done, bin_out, err);
        end
    endtask

    task automatic test_basic();
        logic [9:0] b; logic e; int lat, nr;
        run_conv(12'h012, b, e, lat, nr);
        checks++;
        if (lat !== 11) begin errors++; $display("FAIL basic_latency: got %0d want 11", lat); end
        checks++;
        if (nr !== 11) begin errors++; $display("FAIL basic_ready_low: got %0d want 11", nr); end
        checks++;
        if (b !== 10'd12 || e !== 1'b0) begin
            errors++; $display("FAIL basic_value: got %0d err=%0b want 12 err=0", b, e);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || ready !== 1'b1 || bin_out !== 10'd12) begin
            errors++;
            $display("FAIL done_one_cycle: got done=%0b ready=%0b bin=%0d want done=0 ready=1 bin=12",
                     done, ready, bin_out);
        end
    endtask

    task automatic test_values();
        logic [11:0] vin [4] = '{12'h999, 12'h000, 12'h255, 12'h407};
        int          vexp[4] = '{999, 0, 255, 407};
        logic [9:0] b; logic e; int lat, nr;
        for (int i = 0; i < 4; i++) begin
            run_conv(vin[i], b, e, lat, nr);
            checks++;
            if (lat !== 11 || b !== 10'(vexp[i]) || e !== 1'b0) begin
                errors++;
                $display("FAIL values_%03h: got %0d err=%0b lat=%0d want %0d err=0 lat=11",
                         vin[i], b, e, lat, vexp[i]);
            end
        end
    endtask

    task automatic test_invalid();
        logic [9:0] b; logic e; int lat, nr;
        run_conv(12'h1A5, b, e, lat, nr);
        checks++;
        if (lat !== 11 || b !== 10'd0 || e !== 1'b1) begin
            errors++;
            $display("FAIL invalid_digit: got %0d err=%0b lat=%0d want 0 err=1 lat=11", b, e, lat);
        end
        run_conv(12'h100, b, e, lat, nr);
        checks++;
        if (b !== 10'd100 || e !== 1'b0) begin
            errors++; $display("FAIL err_clears: got %0d err=%0b want 100 err=0", b, e);
        end
    endtask

    task automatic test_hold_start();
        logic [11:0] vals[5] = '{12'h321, 12'h058, 12'h999, 12'h640, 12'h007};
        logic [11:0] pend[$];
        int accepts, dones;
        accepts = 0; dones = 0;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                dones++;
                checks++;
                if (pend.size() == 0) begin
                    errors++; $display("FAIL hold_extra_done: got done with no accepted start want none");
                end else begin
                    logic [11:0] s;
                    s = pend.pop_front();
                    if (bin_out !== 10'(bcd_to_int(s)) || err !== 1'b0) begin
                        errors++;
                        $display("FAIL hold_value: got %0d err=%0b want %0d err=0",
                                 bin_out, err, bcd_to_int(s));
                    end
                end
            end
            bcd_in = vals[i % 5];
            start  = 1'b1;
            if (ready) begin pend.push_back(bcd_in); accepts++; end
            @(negedge clk);
        end
        start = 1'b0;
        for (int c = 0; c < 20 && pend.size() > 0; c++) begin
            if (done) begin
                logic [11:0] s;
                dones++;
                checks++;
                s = pend.pop_front();
                if (bin_out !== 10'(bcd_to_int(s))) begin
                    errors++;
                    $display("FAIL hold_value_tail: got %0d want %0d", bin_out, bcd_to_int(s));
                end
            end
            @(negedge clk);
        end
        checks++;
        if (dones !== accepts || accepts < 3) begin
            errors++; $display("FAIL hold_done_count: got %0d dones want %0d (accepts)", dones, accepts);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        logic [9:0] b; logic e; int lat, nr;
        @(negedge clk);
        bcd_in = 12'h777; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({ready, busy, done, bin_out, err} !== {1'b1, 1'b0, 1'b0, 10'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_state: got r=%0b b=%0b d=%0b bin=%0d e=%0b want r=1 b=0 d=0 bin=0 e=0",
                     ready, busy, done, bin_out, err);
        end
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            if (done) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d want 0", dones); end
        run_conv(12'h042, b, e, lat, nr);
        checks++;
        if (lat !== 11 || b !== 10'd42 || e !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: got %0d err=%0b lat=%0d want 42 err=0 lat=11", b, e, lat);
        end
    endtask

    task automatic test_round_trip();
        logic [9:0] b; logic e; int lat, nr;
        int bad;
        bad = 0;
        for (int n = 0; n < 256; n++) begin
            run_conv(int_to_bcd(n), b, e, lat, nr);
            checks++;
            if (b !== 10'(n) || e !== 1'b0 || lat !== 11) begin
                errors++;
                if (bad < 5)
                    $display("FAIL round_trip_%0d: got %0d err=%0b lat=%0d want %0d err=0 lat=11",
                             n, b, e, lat, n);
                bad++;
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; bcd_in = '0;
        test_reset();
        test_basic();
        test_values();
        test_invalid();
        test_hold_start();
        test_reset_mid();
        test_round_trip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
- Sequential BCD-to-binary converter; the inverse of the existing combinational bin2bcd.
- Uses reverse double-dabble: one right shift plus a per-nibble correction each clock.
- Converts DIGITS packed BCD digits into an unsigned binary value with a start/done handshake.
- Used wherever decimal setpoints (UART/keypad entry, display readback) must feed binary datapaths such as the FOC control loop.

Parameters:
- DIGITS, 3, number of packed BCD digits on bcd_in.
- BIN_W, 10, binary output width. Must satisfy 2^BIN_W > 10^DIGITS - 1. Elaboration-time check fails otherwise.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request conversion; accepted only when ready=1.
- bcd_in  input  4*DIGITS  packed BCD, digit 0 (ones) in [3:0]; sampled on the accepting edge only.
- ready  output  1  high in IDLE; start is accepted this cycle.
- busy  output  1  high while converting (CONV and FIN states).
- done  output  1  one-cycle pulse; bin_out/err valid from this cycle.
- bin_out  output  BIN_W  converted value; holds until the next done.
- err  output  1  one or more input digits were >9; updates with done.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state=IDLE, ready=1, busy=0, done=0, bin_out=0, err=0, counter=0, shift register=0. Reset has priority over start.
- Reset mid-conversion: abort, return to IDLE next cycle, no done pulse, bin_out=0.
- Working register: {bcd_sr[4*DIGITS-1:0], bin_sr[BIN_W-1:0]}. The counter is ceil(log2(BIN_W)) bits.
- IDLE:
  - On start=1 at edge k: load bcd_sr=bcd_in, bin_sr=0, cnt=0.
  - Latch bad = OR over digits of (digit>9).
  - Go to CONV.
  - start=0 stays in IDLE.
- CONV, one step per cycle:
  - Logical right shift of the whole register by 1; bcd_sr LSB enters bin_sr MSB, 0 enters bcd_sr MSB.
  - Then, in the same cycle, subtract 3 from each shifted nibble whose value is >=8 (combinational on the shifted value, registered once).
  - cnt increments each step.
  - After exactly BIN_W steps (cnt==BIN_W-1 step taken), go to FIN.
- FIN (1 cycle):
  - bin_out <= bad ? 0 : bin_sr.
  - err <= bad.
  - done=1 for exactly this one cycle.
  - Next state IDLE.
- Latency:
  - Start sampled at edge k; done high in cycle k+BIN_W+1.
  - That is 11 cycles for defaults, constant regardless of the data or error condition.
- ready=0 and busy=1 from cycle k+1 through FIN inclusive. ready returns to 1 the cycle after done.
- Start while busy: ignored, not queued; bcd_in changes while busy have no effect.
- Back-to-back: start asserted in the first IDLE cycle after done is accepted. Throughput is one conversion per BIN_W+2 cycles.
- Arithmetic: all unsigned, no rounding. Corrections cannot underflow because each is applied only when the nibble is >=8.
- Boundaries:
  - All-zero input gives 0.
  - Maximum input (all 9s) gives 10^DIGITS-1 exactly, with no overflow given the BIN_W constraint.
  - The invalid-digit result is always 0 with err=1; err clears on the next valid conversion.

Test Plan:
- Reset, then bcd_in=12'h012, pulse start -> done exactly 11 cycles later; bin_out=10'd12, err=0; ready low for 11 cycles.
- bcd_in=12'h999 -> bin_out=999 (0x3E7). bcd_in=12'h000 -> bin_out=0. bcd_in=12'h255 -> bin_out=255.
- bcd_in=12'h1A5 (invalid tens digit) -> done at the same latency, bin_out=0, err=1. A following 12'h100 -> bin_out=100, err=0.
- Hold start high continuously and toggle bcd_in while busy -> only the values sampled in ready cycles are converted; exactly one done per accepted start; outputs match the sampled inputs.
- Assert rst for one cycle 5 cycles into a conversion of 12'h777 -> no done pulse; all outputs return to reset values; a new conversion of 12'h042 gives 42.
- Round trip: for bin 0..255, drive bin2bcd output into bcd2bin_seq -> bin_out equals bin for every value and err is never set.
